// File: rtl/lexicase_selector.sv
// Lexicase parent selector. It buffers one population of per-case hit strings,
// filters survivors one case per cycle in a rotated order, then reports the lowest surviving index.
module lexicase_selector #(
    parameter  int POP_SIZE = 8,
    parameter  int CASES    = 16,
    localparam int IDX_W    = $clog2(POP_SIZE),
    localparam int OFF_W    = $clog2(CASES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CASES-1:0] in_hits,
    output logic             pop_full,
    input  logic             clear,
    input  logic             start,
    input  logic [OFF_W-1:0] start_offset,
    output logic             busy,
    output logic             sel_valid,
    output logic [IDX_W-1:0] sel_idx
);

    // state  | meaning
    // LOAD   | accept hit strings; with pop_full set this is the idle state
    // FILTER | evaluate one test case per cycle against the survivors
    // DONE   | one-cycle pulse that presents the selected index
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_FILTER = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [POP_SIZE-1:0] SURV_ALL  = '1;
    localparam logic [POP_SIZE-1:0] SURV_ONE  = POP_SIZE'(1);
    localparam logic [IDX_W:0]      PTR_FULL  = (IDX_W+1)'(POP_SIZE);
    localparam logic [OFF_W:0]      K_LAST    = (OFF_W+1)'(CASES);
    localparam logic [OFF_W-1:0]    CASE_LAST = OFF_W'(CASES - 1);

    logic [1:0]          state_q, state_d;
    logic [IDX_W:0]      wr_ptr_q, wr_ptr_d;
    logic                pop_full_q, pop_full_d;
    logic [POP_SIZE-1:0] survivors_q, survivors_d;
    logic [OFF_W:0]      k_q, k_d;
    logic [OFF_W-1:0]    cur_q, cur_d;
    logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
    logic [CASES-1:0]    mem_q [POP_SIZE];

    logic                wr_en;
    logic [OFF_W-1:0]    bit_sel;
    logic [POP_SIZE-1:0] col;
    logic [POP_SIZE-1:0] surv_nx;
    logic                surv_single;
    logic [OFF_W:0]      k_nx;
    logic [IDX_W-1:0]    lo_idx;

    assign in_ready  = (state_q == ST_LOAD) && !pop_full_q;
    assign pop_full  = pop_full_q;
    assign busy      = (state_q == ST_FILTER);
    assign sel_valid = (state_q == ST_DONE);
    assign sel_idx   = sel_idx_q;

    // Bit CASES-1 of a hit string holds case 0.
    assign bit_sel = CASE_LAST - cur_q;

    always_comb begin
        col = '0;
        for (int i = 0; i < POP_SIZE; i++) begin
            col[i] = survivors_q[i] & mem_q[i][bit_sel];
        end
    end

    // A case that nobody passes leaves the survivor set untouched, so it never empties.
    assign surv_nx     = (col != '0) ? col : survivors_q;
    assign surv_single = ((surv_nx & (surv_nx - SURV_ONE)) == '0);
    assign k_nx        = k_q + (OFF_W+1)'(1);

    always_comb begin
        lo_idx = '0;
        for (int i = POP_SIZE - 1; i >= 0; i--) begin
            if (surv_nx[i]) begin
                lo_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pop_full_d  = pop_full_q;
        survivors_d = survivors_q;
        k_d         = k_q;
        cur_d       = cur_q;
        sel_idx_d   = sel_idx_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (clear) begin
                    wr_ptr_d   = '0;
                    pop_full_d = 1'b0;
                end else begin
                    if (start && pop_full_q) begin
                        state_d     = ST_FILTER;
                        cur_d       = start_offset;
                        survivors_d = SURV_ALL;
                        k_d         = '0;
                    end
                    if (in_valid && !pop_full_q) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + (IDX_W+1)'(1);
                        pop_full_d = (wr_ptr_d == PTR_FULL);
                    end
                end
            end
            ST_FILTER: begin
                survivors_d = surv_nx;
                k_d         = k_nx;
                cur_d       = (cur_q == CASE_LAST) ? '0 : cur_q + OFF_W'(1);
                if (surv_single || (k_nx == K_LAST)) begin
                    state_d   = ST_DONE;
                    sel_idx_d = lo_idx;
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            pop_full_q  <= 1'b0;
            survivors_q <= SURV_ALL;
            k_q         <= '0;
            cur_q       <= '0;
            sel_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pop_full_q  <= pop_full_d;
            survivors_q <= survivors_d;
            k_q         <= k_d;
            cur_q       <= cur_d;
            sel_idx_q   <= sel_idx_d;
        end
    end

    // Buffer contents need no reset; pop_full gates whether they are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= in_hits;
        end
    end

endmodule

// File: doc/lexicase_selector.md
Name: lexicase_selector

Overview:
- Hardware consumer of the per-individual lexicase hit strings that the evaluation bench emits: `{lexi_sum, lexi_co}`, MSB-first, one bit per test case, 1 = hit.
- Buffers one population's hit strings, then runs lexicase selection over the test cases in a rotated order.
- Emits the index of the selected parent to the GE breeding controller.

Parameters:
- POP_SIZE, 8, number of individuals buffered per selection round.
- CASES, 16, hit-string width (8 sum cases followed by 8 co cases).
- IDX_W, $clog2(POP_SIZE), width of individual index (derived, not overridden).
- OFF_W, $clog2(CASES), width of case-order offset (derived).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  hit string on in_hits is valid.
- in_ready  output  1  buffer can accept a hit string.
- in_hits  input  CASES  hit string. Bit CASES-1 = case 0 (first sum vector); bit 0 = case CASES-1 (last co vector).
- pop_full  output  1  all POP_SIZE strings loaded.
- clear  input  1  discard buffered population (ignored while busy).
- start  input  1  begin a selection round (1-cycle pulse).
- start_offset  input  OFF_W  first case examined; order is offset, offset+1, ... mod CASES.
- busy  output  1  selection in progress.
- sel_valid  output  1  one-cycle pulse: sel_idx is new.
- sel_idx  output  IDX_W  selected individual, held until next sel_valid.

Behaviour:
- Reset values (rst=0 at posedge):
  - State LOAD; wr_ptr=0; survivors=all ones; k=0.
  - Outputs: in_ready=1, pop_full=0, busy=0, sel_valid=0, sel_idx=0.
  - Buffer contents don't-care.
- States:
  - LOAD: in_ready=!pop_full. A transfer is in_valid&in_ready at posedge: write mem[wr_ptr], wr_ptr++. When wr_ptr reaches POP_SIZE, set pop_full=1 and deassert in_ready the next cycle. in_valid while full is ignored, no overwrite.
  - IDLE: this is LOAD with pop_full=1. start with pop_full=1 -> FILTER: latch cur=start_offset, survivors=all ones, k=0, busy=1. start while !pop_full is ignored.
  - FILTER: one case per cycle, c=cur.
    - col[i] = survivors[i] & mem[i][CASES-1-c].
    - If col != 0: survivors <= col; else survivors unchanged (a case nobody passes does not eliminate anyone).
    - Then cur <= (cur+1) mod CASES, k++.
    - Go to DONE when the updated survivors has exactly one bit set, or when k reaches CASES (all cases consumed).
  - DONE: one cycle. sel_idx <= lowest set index of survivors; sel_valid=1 for that cycle; busy=0; return to LOAD with pop_full=1 (buffer retained for further rounds).
- Latency: start accepted at cycle 0; case k evaluated at posedge of cycle k+1. Minimum 1 FILTER cycle, maximum CASES. sel_valid asserted the cycle after the final FILTER cycle, i.e. 2..CASES+1 cycles after start.
- clear in LOAD/IDLE: wr_ptr=0, pop_full=0, in_ready=1 next cycle. clear and start in the same cycle: clear wins. Ignored during FILTER/DONE.
- start during FILTER/DONE is ignored, with no restart.
- Reset mid-FILTER aborts the round: no sel_valid, population discarded (pop_full=0).
- survivors never becomes zero; sel_idx is always a valid index < POP_SIZE.

Test Plan:
1. Hold rst=0 for 2 cycles, then release -> in_ready=1, pop_full=0, busy=0, sel_valid=0, sel_idx=0. Pulse start -> ignored, busy stays 0.
2. Load idx0..7 = 16'h7FFF except idx5=16'hFFFF; start_offset=0 -> case 0 leaves {5}. sel_valid at cycle 2 after start, sel_idx=5, pop_full stays 1. Then a 9th in_valid -> not accepted.
3. Load all strings with bit15=0 (case 0 failed by all), idx3=16'h4000, others 16'h0000; offset=0 -> case 0 keeps all, case 1 keeps {3}. sel_valid at cycle 3, sel_idx=3.
4. Load 8 identical strings 16'hA5A5; any offset -> all 16 cases consumed. sel_valid at cycle 17, sel_idx=0.
5. Wrap-around: idx6=16'h0001, others 16'h0000; offset=15 -> case 15 first, selects 6 at cycle 2. Same data, offset=14 -> case 14 no-op, case 15 selects 6 at cycle 3.
6. Pulse rst low at cycle 4 of a 17-cycle round -> no sel_valid, busy=0, pop_full=0, in_ready=1. Reload 8 strings -> normal round. clear+start in the same cycle -> pop_full=0, no round.
